sim_mem_model: RTL and testbench

SIM_MEM_MODEL -- requirements
Module: sim_mem_model

---
 rtl/sim_mem_model.sv | 237 +++++++++++++++++++++++
 tb/tb_sim_mem_model.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_mem_model.sv
// sim_mem_model: byte-addressed behavioural memory with request, write-data, read-data and completion handshakes.
// Optional completion counters are built when SIM_MEM_STATS_EN is defined; otherwise they read as zero.
module sim_mem_model #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned LATENCY    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LEN_W-1:0]        req_len,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DATA_BYTES*8-1:0] wdata,
  output logic                    rdata_valid,
  input  logic                    rdata_ready,
  output logic [DATA_BYTES*8-1:0] rdata,
  output logic                    rdata_last,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_err,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count,
  output logic [31:0]             err_count
);

  localparam int unsigned DATA_W = DATA_BYTES * 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CHK_W  = ADDR_W + LEN_W + 1;
  localparam int unsigned WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} state_t;

  // Two-state storage so every byte reads as zero from time zero; reset never touches it.
  bit [7:0] mem [DEPTH];

  state_t             state_q, state_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   left_q, left_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic               req_ready_d, wdata_ready_d, rdata_valid_d, rdata_last_d;
  logic               resp_valid_d, resp_err_d;
  logic [DATA_W-1:0]  rdata_d;

  logic               mem_we;
  logic [IDX_W-1:0]   rd_ptr;
  logic [DATA_W-1:0]  rd_beat;
  logic [CHK_W-1:0]   req_end;
  logic               req_bad;

  // Range check is done wide enough that the end address can never wrap.
  always_comb begin
    req_end = CHK_W'(req_addr) + (CHK_W'(req_len) + CHK_W'(1)) * CHK_W'(DATA_BYTES);
    req_bad = ((CHK_W'(req_addr) % CHK_W'(DATA_BYTES)) != '0) || (req_end > CHK_W'(DEPTH));
  end

  // Address of the beat that will be loaded into rdata at the next edge.
  always_comb begin
    case (state_q)
      IDLE:    rd_ptr = IDX_W'(req_addr);
      WAIT:    rd_ptr = ptr_q;
      default: rd_ptr = ptr_q + IDX_W'(DATA_BYTES);
    endcase
    rd_beat = '0;
    for (int k = 0; k < int'(DATA_BYTES); k++) begin
      rd_beat[8*k +: 8] = mem[rd_ptr + IDX_W'(k)];
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    ptr_d         = ptr_q;
    left_d        = left_q;
    wait_d        = wait_q;
    req_ready_d   = 1'b0;
    wdata_ready_d = 1'b0;
    rdata_valid_d = 1'b0;
    rdata_last_d  = 1'b0;
    rdata_d       = rdata;
    resp_valid_d  = 1'b0;
    resp_err_d    = resp_err;
    mem_we        = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          wr_d        = req_write;
          ptr_d       = IDX_W'(req_addr);
          left_d      = req_len;
          if (req_bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (LATENCY == 0) begin
            state_d       = XFER;
            wdata_ready_d = req_write;
            rdata_valid_d = !req_write;
            rdata_last_d  = !req_write && (req_len == '0);
            if (!req_write) rdata_d = rd_beat;
          end else begin
            state_d = WAIT;
            wait_d  = WAIT_W'(LATENCY - 1);
          end
        end
      end

      WAIT: begin
        if (wait_q == '0) begin
          state_d       = XFER;
          wdata_ready_d = wr_q;
          rdata_valid_d = !wr_q;
          rdata_last_d  = !wr_q && (left_q == '0);
          if (!wr_q) rdata_d = rd_beat;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      XFER: begin
        if (wr_q) begin
          wdata_ready_d = 1'b1;
          if (wdata_valid && wdata_ready) begin
            mem_we = 1'b1;
            if (left_q == '0) begin
              state_d       = RESP;
              wdata_ready_d = 1'b0;
              resp_valid_d  = 1'b1;
              resp_err_d    = 1'b0;
            end else begin
              ptr_d  = ptr_q + IDX_W'(DATA_BYTES);
              left_d = left_q - LEN_W'(1);
            end
          end
        end else begin
          // Hold the current beat until the consumer takes it.
          rdata_valid_d = 1'b1;
          rdata_last_d  = rdata_last;
          if (rdata_valid && rdata_ready) begin
            if (left_q == '0) begin
              state_d       = RESP;
              rdata_valid_d = 1'b0;
              rdata_last_d  = 1'b0;
              resp_valid_d  = 1'b1;
              resp_err_d    = 1'b0;
            end else begin
              ptr_d        = ptr_q + IDX_W'(DATA_BYTES);
              left_d       = left_q - LEN_W'(1);
              rdata_d      = rd_beat;
              rdata_last_d = (left_q == LEN_W'(1));
            end
          end
        end
      end

      RESP: begin
        resp_valid_d = 1'b1;
        if (resp_valid && resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      ptr_q       <= '0;
      left_q      <= '0;
      wait_q      <= '0;
      req_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      rdata       <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      ptr_q       <= ptr_d;
      left_q      <= left_d;
      wait_q      <= wait_d;
      req_ready   <= req_ready_d;
      wdata_ready <= wdata_ready_d;
      rdata_valid <= rdata_valid_d;
      rdata_last  <= rdata_last_d;
      rdata       <= rdata_d;
      resp_valid  <= resp_valid_d;
      resp_err    <= resp_err_d;
    end
  end

  // Little-endian beat store; a beat arriving on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int k = 0; k < int'(DATA_BYTES); k++) begin
        mem[ptr_q + IDX_W'(k)] <= wdata[8*k +: 8];
      end
    end
  end

`ifdef SIM_MEM_STATS_EN
  // Counted once per completion handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (resp_valid && resp_ready) begin
      if (resp_err)  err_count <= err_count + 32'd1;
      else if (wr_q) wr_count  <= wr_count + 32'd1;
      else           rd_count  <= rd_count + 32'd1;
    end
  end
`else
  assign rd_count  = '0;
  assign wr_count  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_sim_mem_model.sv
// tb_sim_mem_model: randomized self-checking bench for sim_mem_model against a byte-array reference memory.
module tb_sim_mem_model;

  localparam int unsigned DB    = 4;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 10;
`ifdef SIM_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [31:0] rdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] rd_count, wr_count, err_count;

  logic        req_valid_z, req_ready_z, req_write_z;
  logic [31:0] req_addr_z;
  logic [7:0]  req_len_z;
  logic        wdata_valid_z, wdata_ready_z;
  logic [31:0] wdata_z;
  logic        rdata_valid_z, rdata_ready_z, rdata_last_z;
  logic [31:0] rdata_z;
  logic        resp_valid_z, resp_ready_z, resp_err_z;
  logic [31:0] rd_count_z, wr_count_z, err_count_z;

  sim_mem_model #(.DATA_BYTES(DB), .DEPTH(DEPTH), .ADDR_W(32), .LEN_W(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
  );

  sim_mem_model #(.DATA_BYTES(DB), .DEPTH(DEPTH), .ADDR_W(32), .LEN_W(8), .LATENCY(0)) u_dut_z (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_len(req_len_z),
    .wdata_valid(wdata_valid_z), .wdata_ready(wdata_ready_z), .wdata(wdata_z),
    .rdata_valid(rdata_valid_z), .rdata_ready(rdata_ready_z), .rdata(rdata_z), .rdata_last(rdata_last_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z), .resp_err(resp_err_z),
    .rd_count(rd_count_z), .wr_count(wr_count_z), .err_count(err_count_z)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] wbeats [256];
  int          m_rd, m_wr, m_err;
  int          acc_cyc, first_cyc;

  function automatic logic [31:0] model_beat(input logic [31:0] a, input int i);
    logic [31:0] r;
    for (int k = 0; k < int'(DB); k++) r[8*k +: 8] = ref_mem[(int'(a) + i * int'(DB) + k) % int'(DEPTH)];
    return r;
  endfunction

  task automatic send_req(input bit w, input logic [31:0] a, input logic [7:0] l);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL req_accept: req_ready=%b required 1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_len   = 8'($urandom);
  endtask

  task automatic write_beat(input logic [31:0] d);
    int n = 0;
    if ($urandom_range(0, 3) == 0) begin wdata_valid = 1'b0; @(negedge clk); end
    wdata_valid = 1'b1; wdata = d;
    while (wdata_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (wdata_ready !== 1'b1) begin bad++; $display("FAIL wdata_ready: got %b required 1", wdata_ready); end
    @(posedge clk);
    @(negedge clk);
    wdata_valid = 1'b0;
    wdata = $urandom;
  endtask

  task automatic read_beats(input logic [31:0] a, input logic [7:0] l, input int stall);
    int i = 0;
    int n = 0;
    bit first = 1'b1;
    bit prev_stalled = 1'b0;
    bit rdy;
    logic [31:0] prev = '0;
    while (i <= int'(l) && n < 2000) begin
      if (prev_stalled) begin
        total++;
        if (rdata_valid !== 1'b1 || rdata !== prev) begin
          bad++; $display("FAIL rdata_stable: valid=%b data=%h required 1 %h", rdata_valid, rdata, prev);
        end
      end
      if (rdata_valid === 1'b1) begin
        if (first) begin first_cyc = cyc; first = 1'b0; end
        total++;
        if (rdata !== model_beat(a, i)) begin
          bad++; $display("FAIL rdata beat %0d: got %h required %h", i, rdata, model_beat(a, i));
        end
        total++;
        if (rdata_last !== (i == int'(l))) begin
          bad++; $display("FAIL rdata_last beat %0d: got %b required %b", i, rdata_last, i == int'(l));
        end
      end
      if (stall == 0)      rdy = 1'b1;
      else if (stall == 1) rdy = (n % 2 == 1);
      else                 rdy = 1'($urandom_range(0, 1));
      rdata_ready  = rdy;
      prev_stalled = (rdata_valid === 1'b1) && !rdy;
      prev         = rdata;
      if (rdata_valid === 1'b1 && rdy) i++;
      @(negedge clk);
      n++;
    end
    rdata_ready = 1'b0;
    total++;
    if (i != int'(l) + 1) begin bad++; $display("FAIL read_count: got %0d beats required %0d", i, int'(l) + 1); end
  endtask

  task automatic finish_resp(input bit exp_err, input bit w);
    int n = 0;
    while (resp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (resp_valid !== 1'b1) begin bad++; $display("FAIL resp_valid: got %b required 1", resp_valid); end
    total++;
    if (resp_err !== exp_err) begin bad++; $display("FAIL resp_err: got %b required %b", resp_err, exp_err); end
    total++;
    if ({req_ready, wdata_ready, rdata_valid} !== 3'b000) begin
      bad++; $display("FAIL resp_quiet: req_ready/wdata_ready/rdata_valid=%b required 000", {req_ready, wdata_ready, rdata_valid});
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_err !== exp_err) begin
        bad++; $display("FAIL resp_hold: valid=%b err=%b required 1 %b", resp_valid, resp_err, exp_err);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    if (exp_err) m_err++; else if (w) m_wr++; else m_rd++;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL resp_done: resp_valid=%b req_ready=%b required 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic run_txn(input bit w, input logic [31:0] a, input logic [7:0] l, input int stall);
    bit err;
    err = ((a % DB) != 0) || ((64'(a) + (64'(l) + 64'd1) * 64'(DB)) > 64'(DEPTH));
    send_req(w, a, l);
    if (err) begin
      wdata_valid = 1'b1;
      total++;
      if (wdata_ready !== 1'b0 || rdata_valid !== 1'b0) begin
        bad++; $display("FAIL reject_quiet: wdata_ready=%b rdata_valid=%b required 0 0", wdata_ready, rdata_valid);
      end
      wdata_valid = 1'b0;
    end else if (w) begin
      for (int i = 0; i <= int'(l); i++) begin
        write_beat(wbeats[i]);
        for (int k = 0; k < int'(DB); k++) ref_mem[(int'(a) + i * int'(DB) + k) % int'(DEPTH)] = wbeats[i][8*k +: 8];
      end
    end else begin
      read_beats(a, l, stall);
    end
    finish_resp(err, w);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
    total++;
    if ({wdata_ready, rdata_valid, rdata_last, resp_valid, resp_err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b required 00000", {wdata_ready, rdata_valid, rdata_last, resp_valid, resp_err});
    end
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h required 0", rdata); end
    total++;
    if ({rd_count, wr_count, err_count} !== 96'h0) begin
      bad++; $display("FAIL reset_counters: got %0d %0d %0d required 0 0 0", rd_count, wr_count, err_count);
    end
    rst = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_basic;
    wbeats[0] = 32'h11111111; wbeats[1] = 32'h22222222;
    wbeats[2] = 32'h33333333; wbeats[3] = 32'h44444444;
    run_txn(1'b1, 32'h10, 8'd3, 0);
    run_txn(1'b0, 32'h10, 8'd3, 0);
    run_txn(1'b0, 32'h200, 8'd2, 0);
  endtask

  task automatic test_latency;
    first_cyc = -1;
    run_txn(1'b0, 32'h10, 8'd0, 0);
    total++;
    if (first_cyc - acc_cyc != int'(LAT)) begin
      bad++; $display("FAIL latency: first beat %0d cycles after accept, required %0d", first_cyc - acc_cyc, LAT);
    end
  endtask

  task automatic test_latency_zero;
    int n = 0;
    req_valid_z = 1'b1;
    while (req_ready_z !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid_z = 1'b0;
    total++;
    if (rdata_valid_z !== 1'b1) begin bad++; $display("FAIL lat0_valid: got %b required 1 right after accept", rdata_valid_z); end
    total++;
    if (rdata_z !== 32'h0 || rdata_last_z !== 1'b1 || wdata_ready_z !== 1'b0) begin
      bad++; $display("FAIL lat0_beat: data=%h last=%b wready=%b required 0 1 0", rdata_z, rdata_last_z, wdata_ready_z);
    end
    @(negedge clk);
    total++;
    if (resp_valid_z !== 1'b1 || resp_err_z !== 1'b0 || rdata_valid_z !== 1'b0) begin
      bad++; $display("FAIL lat0_resp: valid=%b err=%b rvalid=%b required 1 0 0", resp_valid_z, resp_err_z, rdata_valid_z);
    end
    resp_ready_z = 1'b1;
    @(negedge clk);
    resp_ready_z = 1'b0;
    total++;
    if (rd_count_z !== (STATS ? 32'd1 : 32'd0) || wr_count_z !== 32'd0 || err_count_z !== 32'd0) begin
      bad++; $display("FAIL lat0_counters: got %0d %0d %0d required %0d 0 0", rd_count_z, wr_count_z, err_count_z, STATS ? 1 : 0);
    end
  endtask

  task automatic test_reject;
    for (int i = 0; i < 256; i++) wbeats[i] = $urandom;
    run_txn(1'b0, 32'd1016, 8'd1, 0);
    run_txn(1'b0, 32'd1020, 8'd1, 0);
    run_txn(1'b0, 32'h02, 8'd0, 0);
    run_txn(1'b1, 32'h06, 8'd1, 0);
    run_txn(1'b0, 32'hFFFF_FFFC, 8'hFF, 0);
    run_txn(1'b1, 32'd1020, 8'd0, 0);
    run_txn(1'b0, 32'd1016, 8'd1, 0);
    run_txn(1'b0, 32'h04, 8'd1, 0);
  endtask

  task automatic test_stall;
    for (int i = 0; i < 256; i++) wbeats[i] = $urandom;
    run_txn(1'b1, 32'h100, 8'd7, 0);
    run_txn(1'b0, 32'h100, 8'd7, 1);
  endtask

  task automatic test_reset_mid_write;
    for (int i = 0; i < 4; i++) wbeats[i] = $urandom;
    send_req(1'b1, 32'h10, 8'd3);
    for (int i = 0; i < 2; i++) begin
      write_beat(wbeats[i]);
      for (int k = 0; k < int'(DB); k++) ref_mem[16 + i * int'(DB) + k] = wbeats[i][8*k +: 8];
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, wdata_ready, rdata_valid, rdata_last, resp_valid, resp_err} !== 6'b0) begin
      bad++; $display("FAIL midwrite_reset_flags: got %b required 000000", {req_ready, wdata_ready, rdata_valid, rdata_last, resp_valid, resp_err});
    end
    rst = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL midwrite_idle: req_ready=%b required 1", req_ready); end
    run_txn(1'b0, 32'h10, 8'd3, 0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 30; t++) begin
      bit          w;
      logic [7:0]  l;
      logic [31:0] a;
      int          kind;
      w    = 1'($urandom_range(0, 1));
      l    = 8'($urandom_range(0, 15));
      a    = 32'($urandom_range(0, DEPTH / DB - 1) * DB);
      kind = $urandom_range(0, 5);
      if (kind == 0)      a = a | 32'($urandom_range(1, 3));
      else if (kind == 1) a = 32'(DEPTH) - (32'(l) + 32'($urandom_range(0, 2))) * 32'(DB);
      for (int i = 0; i < 256; i++) wbeats[i] = $urandom;
      run_txn(w, a, l, 2);
    end
  endtask

  task automatic test_counters;
    total++;
    if (rd_count !== (STATS ? 32'(m_rd) : 32'd0) || wr_count !== (STATS ? 32'(m_wr) : 32'd0)
        || err_count !== (STATS ? 32'(m_err) : 32'd0)) begin
      bad++; $display("FAIL counters: got rd=%0d wr=%0d err=%0d required %0d %0d %0d", rd_count, wr_count, err_count,
                      STATS ? m_rd : 0, STATS ? m_wr : 0, STATS ? m_err : 0);
    end
  endtask

  task automatic test_stats;
    do_reset();
    for (int i = 0; i < 256; i++) wbeats[i] = $urandom;
    run_txn(1'b1, 32'h40, 8'd1, 0);
    run_txn(1'b1, 32'h80, 8'd0, 0);
    run_txn(1'b0, 32'h40, 8'd1, 2);
    run_txn(1'b0, 32'h80, 8'd0, 0);
    run_txn(1'b0, 32'h00, 8'd3, 0);
    run_txn(1'b0, 32'h03, 8'd0, 0);
    total++;
    if (wr_count !== (STATS ? 32'd2 : 32'd0) || rd_count !== (STATS ? 32'd3 : 32'd0)
        || err_count !== (STATS ? 32'd1 : 32'd0)) begin
      bad++; $display("FAIL stats_scenario: got wr=%0d rd=%0d err=%0d required %0d %0d %0d", wr_count, rd_count, err_count,
                      STATS ? 2 : 0, STATS ? 3 : 0, STATS ? 1 : 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0; resp_ready = 1'b0;
    req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = 32'h40; req_len_z = 8'd0;
    wdata_valid_z = 1'b0; wdata_z = '0; rdata_ready_z = 1'b1; resp_ready_z = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 0;
    acc_cyc = 0; first_cyc = -1;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_latency();
    test_latency_zero();
    test_reject();
    test_stall();
    test_reset_mid_write();
    test_random();
    test_counters();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
